// File: rtl/alu_muldiv.sv
// Execute-stage ALU: registered base integer ops plus iterative multiply/divide/remainder,
// one bit per cycle, behind a valid/ready handshake with synchronous kill.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_alu_valid,
    output logic            o_alu_ready,
    input  logic [4:0]      i_alu_operator,
    input  logic [XLEN-1:0] i_alu_operand_1,
    input  logic [XLEN-1:0] i_alu_operand_2,
    input  logic            i_alu_kill,
    output logic [XLEN-1:0] o_alu_output,
    output logic            o_alu_out_valid,
    output logic            o_alu_zero,
    output logic            o_alu_illegal
);

    localparam int SW = $clog2(XLEN);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SLL  = 5'b00101;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b00111;
    localparam logic [4:0] OP_SLT  = 5'b01000;
    localparam logic [4:0] OP_SLTU = 5'b01001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] acc_hi_q, acc_lo_q, opb_q;
    logic            is_div_q, sel_hi_q, res_neg_q;

    logic [XLEN-1:0] a, b;
    logic [SW-1:0]   shamt;
    logic            is_m, is_div, is_rem, div_signed, a_signed, b_signed;
    logic            neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, base_res, quick_res;
    logic            base_ill, quick_ill;

    assign a     = i_alu_operand_1;
    assign b     = i_alu_operand_2;
    assign shamt = i_alu_operand_2[SW-1:0];

    // NOTE: every signal driven in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        is_m       = (i_alu_operator[4:3] == 2'b10);
        is_div     = is_m && i_alu_operator[2];
        is_rem     = i_alu_operator[1];
        div_signed = !i_alu_operator[0];
        a_signed   = 1'b0;
        b_signed   = 1'b0;
        if (is_div) begin
            a_signed = div_signed;
            b_signed = div_signed;
        end else if (is_m) begin
            a_signed = (i_alu_operator[1:0] == 2'b01) || (i_alu_operator[1:0] == 2'b10);
            b_signed = (i_alu_operator[1:0] == 2'b01);
        end
        neg_a    = a_signed && a[XLEN-1];
        neg_b    = b_signed && b[XLEN-1];
        mag_a    = neg_a ? -a : a;
        mag_b    = neg_b ? -b : b;
        div_zero = is_div && (b == '0);
        div_ovf  = is_div && div_signed && (a == MIN_NEG) && (b == '1);
    end

    always_comb begin
        base_res = '0;
        base_ill = 1'b0;
        case (i_alu_operator)
            OP_ADD:  base_res = a + b;
            OP_SUB:  base_res = a - b;
            OP_AND:  base_res = a & b;
            OP_OR:   base_res = a | b;
            OP_XOR:  base_res = a ^ b;
            OP_SLL:  base_res = a << shamt;
            OP_SRL:  base_res = a >> shamt;
            OP_SRA:  base_res = $unsigned($signed(a) >>> shamt);
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (a < b)};
            default: base_ill = 1'b1;
        endcase

        // Division corner cases bypass the iteration and finish like a base op.
        quick_ill = base_ill && !is_m;
        if (div_zero)     quick_res = is_rem ? a : '1;
        else if (div_ovf) quick_res = is_rem ? '0 : MIN_NEG;
        else              quick_res = base_res;
    end

    // One iteration step: shift-add multiply or restoring divide on {acc_hi, acc_lo}.
    logic [XLEN:0]     mul_sum, rem_shift, div_diff;
    logic [XLEN-1:0]   step_hi, step_lo, div_val, iter_res;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        rem_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_diff  = rem_shift - {1'b0, opb_q};
        if (is_div_q) begin
            step_hi = div_diff[XLEN] ? rem_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            step_lo = {acc_lo_q[XLEN-2:0], !div_diff[XLEN]};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        end
        prod    = {step_hi, step_lo};
        prod_s  = res_neg_q ? -prod : prod;
        div_val = sel_hi_q ? step_hi : step_lo;
        if (is_div_q)      iter_res = res_neg_q ? -div_val : div_val;
        else if (sel_hi_q) iter_res = prod_s[2*XLEN-1:XLEN];
        else               iter_res = prod_s[XLEN-1:0];
    end

    assign o_alu_ready = (state_q != BUSY);

    logic            accept, start_iter, load_res, ill_d;
    logic [XLEN-1:0] res_d;

    always_comb begin
        state_d    = state_q;
        start_iter = 1'b0;
        load_res   = 1'b0;
        res_d      = '0;
        ill_d      = 1'b0;
        accept     = i_alu_valid && o_alu_ready && !i_alu_kill;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (is_m && !div_zero && !div_ovf) begin
                        state_d    = BUSY;
                        start_iter = 1'b1;
                    end else begin
                        state_d  = DONE;
                        load_res = 1'b1;
                        res_d    = quick_res;
                        ill_d    = quick_ill;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d  = DONE;
                    load_res = 1'b1;
                    res_d    = iter_res;
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_alu_kill) begin
            state_d    = IDLE;
            start_iter = 1'b0;
            load_res   = 1'b0;
        end
    end

    // NOTE: state and datapath registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q           <= '0;
            acc_hi_q        <= '0;
            acc_lo_q        <= '0;
            opb_q           <= '0;
            is_div_q        <= 1'b0;
            sel_hi_q        <= 1'b0;
            res_neg_q       <= 1'b0;
            o_alu_output    <= '0;
            o_alu_out_valid <= 1'b0;
            o_alu_zero      <= 1'b1;
            o_alu_illegal   <= 1'b0;
        end else begin
            o_alu_out_valid <= (state_d == DONE);
            if (load_res) begin
                o_alu_output  <= res_d;
                o_alu_zero    <= (res_d == '0);
                o_alu_illegal <= ill_d;
            end
            if (start_iter) begin
                cnt_q     <= CW'(XLEN);
                acc_hi_q  <= '0;
                acc_lo_q  <= mag_a;
                opb_q     <= mag_b;
                is_div_q  <= is_div;
                sel_hi_q  <= is_div ? is_rem : (i_alu_operator[1:0] != 2'b00);
                res_neg_q <= (is_div && is_rem) ? neg_a : (neg_a ^ neg_b);
            end else if (i_alu_kill) begin
                cnt_q <= '0;
            end else if (state_q == BUSY) begin
                cnt_q    <= cnt_q - CW'(1);
                acc_hi_q <= step_hi;
                acc_lo_q <= step_lo;
            end
        end
    end

endmodule
